multiplier_unit: RTL and testbench

Sequential 64x64 integer multiplier serving the LEGv8 MUL, SMULH and UMULH instructions. It sits downstream of the decode stage and consumes `mult_start`, `mult_mode` and the two register read operands. It iterates over several cycles, raises `stall` while working, and returns the selected 64-bit half of the 128-bit product together with a one-cycle `multiplier_done` pulse, which decode's control logic consumes.

---
 rtl/multiplier_unit_pkg.sv | 32 +++
 rtl/multiplier_unit_step.sv | 56 +++++
 rtl/multiplier_unit.sv | 155 +++++++++++++++
 tb/tb_multiplier_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_unit_pkg.sv
// Shared constants and types for the sequential multiplier.
// Build option: define MULT_RADIX4_EN to retire two multiplier bits per cycle.
package multiplier_unit_pkg;

  localparam int unsigned WORD = 64;

  // Operation encodings on mult_mode; 2'b11 behaves as MULT_MUL.
  localparam logic [1:0] MULT_MUL   = 2'b00;
  localparam logic [1:0] MULT_SMULH = 2'b01;
  localparam logic [1:0] MULT_UMULH = 2'b10;

`ifdef MULT_RADIX4_EN
  localparam int unsigned MULT_STEP_BITS = 2;
`else
  localparam int unsigned MULT_STEP_BITS = 1;
`endif

  localparam int unsigned MULT_ITERS = WORD / MULT_STEP_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // SMULH and UMULH return the upper half of the product.
  function automatic logic high_half_sel(input logic [1:0] mode);
    return (mode == MULT_SMULH) || (mode == MULT_UMULH);
  endfunction

endpackage

// File: rtl/multiplier_unit_step.sv
// One shift-add iteration of the multiplier datapath (purely combinational).
// Ports: acc (2*WIDTH accumulator), mcand, [mcand3 with MULT_RADIX4_EN], mplier
//        -> acc_next, mplier_next.
// Build option: MULT_RADIX4_EN selects the two-bit-per-step variant.
module mult_step
  import multiplier_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WORD
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
`ifdef MULT_RADIX4_EN
  input  logic [WIDTH+1:0]   mcand3,
`endif
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   mplier_next
);

  localparam int unsigned AW = 2 * WIDTH;

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0]   addend;
  logic [WIDTH+1:0]   sum;
  logic [AW+1:0]      wide;

  // Upper half stays below the multiplicand, so acc_hi + 3*mcand fits in WIDTH+2 bits.
  always_comb begin
    addend = '0;
    case (mplier[1:0])
      2'd1:    addend = {2'b00, mcand};
      2'd2:    addend = {1'b0, mcand, 1'b0};
      2'd3:    addend = mcand3;
      default: addend = '0;
    endcase
    sum         = {2'b00, acc[AW-1:WIDTH]} + addend;
    wide        = {sum, acc[WIDTH-1:0]};
    acc_next    = AW'(wide >> 2);
    mplier_next = mplier >> 2;
  end
`else
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [AW:0]        wide;

  // Add into the upper half with carry-out, then shift the whole accumulator right by one.
  always_comb begin
    addend      = mplier[0] ? {1'b0, mcand} : '0;
    sum         = {1'b0, acc[AW-1:WIDTH]} + addend;
    wide        = {sum, acc[WIDTH-1:0]};
    acc_next    = AW'(wide >> 1);
    mplier_next = mplier >> 1;
  end
`endif

endmodule

// File: rtl/multiplier_unit.sv
// Sequential WIDTH x WIDTH multiplier for MUL / SMULH / UMULH.
// Ports: clk, reset (async active-low), mult_start, mult_mode[1:0], a, b ->
//        result (selected product half), multiplier_done (1-cycle pulse), stall.
// Build option: MULT_RADIX4_EN halves the number of CALC cycles.
module multiplier_unit
  import multiplier_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic [1:0]       mult_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             multiplier_done,
  output logic             stall
);

  localparam int unsigned AW    = 2 * WIDTH;
  localparam int unsigned ITERS = (WIDTH == WORD) ? MULT_ITERS : WIDTH / MULT_STEP_BITS;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               neg_q, neg_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_d;
  logic               done_d;
  logic               stall_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic               neg_in;
  logic [AW-1:0]      step_acc;
  logic [WIDTH-1:0]   step_mplier;
  logic [AW-1:0]      acc_fix;

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0]   mcand3_q, mcand3_d;
`endif

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc_q),
    .mcand       (mcand_q),
`ifdef MULT_RADIX4_EN
    .mcand3      (mcand3_q),
`endif
    .mplier      (mplier_q),
    .acc_next    (step_acc),
    .mplier_next (step_mplier)
  );

  // Signed high half: multiply magnitudes, negate the full product afterwards.
  assign acc_fix = neg_q ? (~acc_q + AW'(1)) : acc_q;

  // Operand conditioning at accept; |-2^(W-1)| is representable as unsigned.
  always_comb begin
    op_a   = a;
    op_b   = b;
    neg_in = 1'b0;
    if (mult_mode == MULT_SMULH) begin
      op_a   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
      op_b   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
      neg_in = a[WIDTH-1] ^ b[WIDTH-1];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result;
    done_d   = 1'b0;
    stall_d  = stall;
`ifdef MULT_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          mode_d   = mult_mode;
          neg_d    = neg_in;
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = CNT_W'(ITERS);
          stall_d  = 1'b1;
          state_d  = S_CALC;
`ifdef MULT_RADIX4_EN
          mcand3_d = {2'b00, op_a} + {1'b0, op_a, 1'b0};
`endif
        end
      end
      S_CALC: begin
        acc_d    = step_acc;
        mplier_d = step_mplier;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = high_half_sel(mode_q) ? acc_fix[AW-1:WIDTH] : acc_fix[WIDTH-1:0];
        done_d   = 1'b1;
        stall_d  = 1'b0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      mode_q          <= '0;
      neg_q           <= 1'b0;
      acc_q           <= '0;
      mcand_q         <= '0;
      mplier_q        <= '0;
      cnt_q           <= '0;
      result          <= '0;
      multiplier_done <= 1'b0;
      stall           <= 1'b0;
`ifdef MULT_RADIX4_EN
      mcand3_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      neg_q           <= neg_d;
      acc_q           <= acc_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      cnt_q           <= cnt_d;
      result          <= result_d;
      multiplier_done <= done_d;
      stall           <= stall_d;
`ifdef MULT_RADIX4_EN
      mcand3_q        <= mcand3_d;
`endif
    end
  end

endmodule

// File: tb/tb_multiplier_unit.sv
// Directed bench for multiplier_unit: vector table plus start-ignore, reset and back-to-back sequences.
module tb_multiplier_unit;

  localparam int unsigned W = 64;
`ifdef MULT_RADIX4_EN
  localparam int DONE_EDGES = 33;
`else
  localparam int DONE_EDGES = 65;
`endif
  localparam int BUDGET = 200;
  localparam int NVEC   = 13;

  logic         clk = 1'b0;
  logic         reset;
  logic         mult_start;
  logic [1:0]   mult_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         multiplier_done;
  logic         stall;

  int n_checks = 0;
  int n_fail   = 0;

  multiplier_unit dut (
    .clk             (clk),
    .reset           (reset),
    .mult_start      (mult_start),
    .mult_mode       (mult_mode),
    .a               (a),
    .b               (b),
    .result          (result),
    .multiplier_done (multiplier_done),
    .stall           (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, got, exp);
    end
  endtask

  // Present an operation and step through its accept edge; scramble inputs afterwards.
  task automatic launch(input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                        input bit hold_start);
    @(negedge clk);
    mult_mode  = m;
    a          = x;
    b          = y;
    mult_start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) begin
      mult_start = 1'b0;
      mult_mode  = ~m;
      a          = {$urandom, $urandom};
      b          = {$urandom, $urandom};
    end
  endtask

  // Wait for done (n0 edges already elapsed since accept) and check latency, result, stall and pulse width.
  task automatic finish_op(input string nm, input logic [63:0] exp, input int n0);
    int n;
    bit seen;
    bit stall_ok;
    n        = n0;
    seen     = 1'b0;
    stall_ok = (stall === 1'b1);
    while (!seen && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
      if (multiplier_done === 1'b1) seen = 1'b1;
      else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    check({nm, " latency"}, 64'(n), 64'(DONE_EDGES));
    check({nm, " result"}, result, exp);
    check({nm, " stall at done"}, {63'b0, stall}, 64'd0);
    check({nm, " stall while busy"}, {63'b0, stall_ok}, 64'd1);
    @(posedge clk);
    #1;
    check({nm, " done pulse width"}, {63'b0, multiplier_done}, 64'd0);
    check({nm, " stall after done"}, {63'b0, stall}, 64'd0);
  endtask

  // Count done pulses and stall cycles over a quiet window.
  task automatic quiet_window(input string nm, input int edges);
    int pulses;
    int stalls;
    pulses = 0;
    stalls = 0;
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
      #1;
      if (multiplier_done === 1'b1) pulses++;
      if (stall === 1'b1) stalls++;
    end
    check({nm, " extra done pulses"}, 64'(pulses), 64'd0);
    check({nm, " extra stall cycles"}, 64'(stalls), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 64'd3, 64'd5, 64'd15};
    vecs[1]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[3]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
    vecs[4]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[5]  = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[6]  = '{2'b11, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001};
    vecs[7]  = '{2'b10, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'd1};
    vecs[8]  = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[10] = '{2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF};
    vecs[11] = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0};
    vecs[12] = '{2'b01, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0};

    reset      = 1'b0;
    mult_start = 1'b0;
    mult_mode  = 2'b00;
    a          = '0;
    b          = '0;
    #22;
    check("reset result", result, 64'd0);
    check("reset done", {63'b0, multiplier_done}, 64'd0);
    check("reset stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      launch(vecs[i].mode, vecs[i].x, vecs[i].y, 1'b0);
      finish_op($sformatf("vec%0d", i), vecs[i].exp, 0);
    end

    // Start pulse at cycle 10 with other operands is ignored.
    launch(2'b00, 64'd3, 64'd5, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    mult_mode  = 2'b00;
    a          = 64'd7;
    b          = 64'd6;
    mult_start = 1'b1;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    finish_op("ignored start", 64'd15, 10);
    quiet_window("ignored start", 80);

    // Reset at cycle 30 discards the operation and clears outputs immediately.
    launch(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midreset stall", {63'b0, stall}, 64'd0);
    check("midreset done", {63'b0, multiplier_done}, 64'd0);
    check("midreset result", result, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    quiet_window("after reset", 70);
    check("after reset result", result, 64'd0);
    launch(2'b00, 64'd7, 64'd6, 1'b0);
    finish_op("mul 7x6", 64'd42, 0);

    // Start held through DONE launches the next operation right after IDLE is re-entered.
    launch(2'b00, 64'd3, 64'd5, 1'b1);
    finish_op("b2b first", 64'd15, 0);
    a = 64'd7;
    b = 64'd6;
    @(posedge clk);
    #1;
    check("b2b accept stall", {63'b0, stall}, 64'd1);
    mult_start = 1'b0;
    mult_mode  = 2'b10;
    a          = 64'hFFFF_FFFF_FFFF_FFFF;
    b          = 64'hFFFF_FFFF_FFFF_FFFF;
    finish_op("b2b second", 64'd42, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
